multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Moore FSM that sequences the shared multicycle datapath (one memory, one ALU, register file) over multiple cycles per instruction.
//  Sits between the instruction register and the datapath muxes/enables.
//  Decodes op/funct/rd each instruction and issues per-cycle selects, write enables and ALU control.
//  Stalls on a memory ready handshake.
// PARAMETERS
//  ALU_CTL_W  3  width of alu_control (fixed encoding below; must be >=3)
//  STATE_W    4  state register width (11 states max)
// PORTS
//  clk          in   1  rising-edge clock
//  rst_n        in   1  asynchronous, active-low reset
//  op           in   2  instr[27:26]: 0 data-proc, 1 ldr/str, 2 branch, 3 illegal
//  funct        in   6  instr[25:20]: [5] imm, [4:1] cmd, [0] S / L
//  rd           in   4  destination register
//  cond_ex      in   1  condition check result (valid from DECODE onward)
//  mem_ready    in   1  memory completes access this cycle
//  pc_write     out  1  PC load enable
//  adr_src      out  1  0 PC, 1 ALU result as memory address
//  ir_write     out  1  instruction register load
//  mem_w        out  1  memory write strobe
//  reg_w        out  1  register file write
//  alu_src_a    out  1  0 rn, 1 PC
//  alu_src_b    out  2  0 reg, 1 ext imm, 2 const 4
//  result_src   out  2  0 ALUOut reg, 1 data reg, 2 ALU direct
//  imm_src      out  2  0 dp imm8, 1 mem imm12, 2 branch imm24
//  reg_src      out  2  [0] rn=PC for branch, [1] rm=rd for str
//  alu_control  out  ALU_CTL_W  000 add,001 sub,010 and,011 or,100 adc,111 eor
//  flag_w       out  2  [1] NZ write, [0] CV write
//  shift_flag   out  1  lsl selected (cmd 1101)
//  trap         out  1  illegal op reached (only with MC_ILLEGAL_TRAP_EN)
// BEHAVIOUR
//  States: FETCH DECODE MEMADR MEMRD MEMWB MEMWR EXECR EXECI ALUWB BRANCH [TRAP].
//  Reset: state=FETCH asynchronously; while rst_n=0 all enables/strobes 0, selects 0, trap 0.
//  FETCH: adr_src=0, a=PC, b=4, result_src=2, add.
//   Stays until mem_ready; on ready: ir_write=1, pc_write=1, ->DECODE.
//  DECODE: a=PC, b=4, add. Next state:
//   op0: funct[5] ? EXECI : EXECR.
//   op1: MEMADR.
//   op2: BRANCH.
//   op3: FETCH (or TRAP).
//  MEMADR: a=rn, b=imm (imm_src=1), add; funct[0] ? MEMRD : MEMWR.
//  MEMRD: adr_src=1; wait mem_ready -> MEMWB.
//  MEMWB: result_src=1, reg_w=cond_ex; ->FETCH.
//  MEMWR: adr_src=1, reg_src[1]=1, mem_w=cond_ex held until mem_ready; ->FETCH.
//  EXECR/EXECI: b=reg / imm (imm_src=0); alu_control from cmd; ->ALUWB.
//   flag_w[1]=funct[0]&cond_ex; flag_w[0] additionally requires add/sub class.
//  cmd map: 0100 add, 0010 sub, 0000 and, 1100 or, 1010 cmp=sub, 1000 tst=and,
//   1011 cmn=add, 0101 adc, 0001 eor, 1101 lsl=add + shift_flag; unlisted -> add.
//  ALUWB: result_src=0.
//   reg_w=cond_ex unless cmd in {cmp,tst,cmn}; then reg_w=0, state still ->FETCH.
//  BRANCH: reg_src[0]=1, imm_src=2, a=rn(PC+8), b=imm, result_src=2, pc_write=cond_ex; ->FETCH.
//  rd==15 with reg_w in MEMWB/ALUWB also asserts pc_write (result to PC).
//  Latency, zero-wait memory: DP 4 cycles, LDR 5, STR 4, B 3; each mem wait adds 1.
//  cond_ex=0: instruction still walks all its states; every write/strobe suppressed.
//  rst_n low mid-instruction: aborts immediately; no partial write after release.
// CONFIGURATION
//  MC_ILLEGAL_TRAP_EN defined:
//   op==3 in DECODE -> TRAP; trap=1; all enables 0; left only via reset.
//  MC_ILLEGAL_TRAP_EN undefined:
//   op==3 is a NOP (DECODE->FETCH); trap tied 0; TRAP state absent.
// TESTING
//  1. ADD r1,r2,r3, cond_ex=1, mem_ready=1:
//     FETCH,DECODE,EXECR,ALUWB; reg_w=1 cycle 4 only; alu_control=000.
//  2. LDR, mem_ready low 2 cycles in MEMRD:
//     state MEMRD holds 3 cycles; reg_w once in MEMWB; total 7 cycles.
//  3. CMP (cmd 1010,S=1):
//     alu_control=001, flag_w=11 in EXECR; reg_w=0 in ALUWB.
//  4. B with cond_ex=0: pc_write=0 in BRANCH, back to FETCH.
//     ADD rd=15: pc_write=1 in ALUWB.
//  5. rst_n low during MEMWR: mem_w drops same cycle.
//     After release: FETCH, adr_src=0; op=3 -> trap=1 only when MC_ILLEGAL_TRAP_EN defined.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// -----------------------------------------------------------------------------
// multicycle_controller_if
// Bundles the instruction-field inputs, the condition/memory handshake and all
// datapath control outputs of the multicycle controller.
//   master : controller side (consumes instruction fields, drives controls)
//   slave  : datapath side (supplies instruction fields, consumes controls)
// Parameter ALU_CTL_W sets the alu_control width (>= 3).
// -----------------------------------------------------------------------------
interface multicycle_controller_if #(
    parameter int ALU_CTL_W = 3
);
    // instruction fields and status
    logic [1:0]           op;
    logic [5:0]           funct;
    logic [3:0]           rd;
    logic                 cond_ex;
    logic                 mem_ready;
    // datapath controls
    logic                 pc_write;
    logic                 adr_src;
    logic                 ir_write;
    logic                 mem_w;
    logic                 reg_w;
    logic                 alu_src_a;
    logic [1:0]           alu_src_b;
    logic [1:0]           result_src;
    logic [1:0]           imm_src;
    logic [1:0]           reg_src;
    logic [ALU_CTL_W-1:0] alu_control;
    logic [1:0]           flag_w;
    logic                 shift_flag;
    logic                 trap;

    modport master (
        input  op, funct, rd, cond_ex, mem_ready,
        output pc_write, adr_src, ir_write, mem_w, reg_w, alu_src_a, alu_src_b,
               result_src, imm_src, reg_src, alu_control, flag_w, shift_flag, trap
    );

    modport slave (
        output op, funct, rd, cond_ex, mem_ready,
        input  pc_write, adr_src, ir_write, mem_w, reg_w, alu_src_a, alu_src_b,
               result_src, imm_src, reg_src, alu_control, flag_w, shift_flag, trap
    );
endinterface

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
// Moore-style FSM sequencing a shared multicycle datapath (single memory, one
// ALU, register file). Each instruction walks FETCH/DECODE and then a
// class-specific path; the FETCH, MEMRD and MEMWR states stall on mem_ready.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset (state -> FETCH, all outputs 0)
//   bus    : multicycle_controller_if.master
//            in  : op, funct, rd, cond_ex, mem_ready
//            out : pc_write, adr_src, ir_write, mem_w, reg_w, alu_src_a,
//                  alu_src_b, result_src, imm_src, reg_src, alu_control,
//                  flag_w, shift_flag, trap
//
// Parameters:
//   ALU_CTL_W : alu_control width (>= 3, encoding zero-extended)
//   STATE_W   : state register width (>= 4)
//
// Configuration macro:
//   MC_ILLEGAL_TRAP_EN : when defined, op==3 in DECODE enters a TRAP state that
//                        raises trap and is left only through reset. When
//                        undefined, op==3 behaves as a NOP and trap is tied 0.
//
// Outputs are decoded directly from the state register (plus cond_ex,
// mem_ready and the instruction fields) so that a stall, a suppressed write or
// a reset takes effect within the current cycle.
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int ALU_CTL_W = 3,
    parameter int STATE_W   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_controller_if.master bus
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH
`ifdef MC_ILLEGAL_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    // data-processing command field values
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ADC = 4'b0101;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_CMN = 4'b1011;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_LSL = 4'b1101;

    // ALU operation encoding
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_ADC = 3'b100;
    localparam logic [2:0] ALU_EOR = 3'b111;

    // Maps a data-processing command to the ALU operation; unknown commands add.
    function automatic logic [2:0] cmd_to_alu(input logic [3:0] cmd);
        logic [2:0] alu;
        case (cmd)
            CMD_ADD: alu = ALU_ADD;
            CMD_SUB: alu = ALU_SUB;
            CMD_AND: alu = ALU_AND;
            CMD_ORR: alu = ALU_ORR;
            CMD_CMP: alu = ALU_SUB;
            CMD_TST: alu = ALU_AND;
            CMD_CMN: alu = ALU_ADD;
            CMD_ADC: alu = ALU_ADC;
            CMD_EOR: alu = ALU_EOR;
            CMD_LSL: alu = ALU_ADD;
            default: alu = ALU_ADD;
        endcase
        return alu;
    endfunction

    // Commands whose carry/overflow come from the adder (C and V meaningful).
    function automatic logic cmd_is_arith(input logic [3:0] cmd);
        logic arith;
        case (cmd)
            CMD_ADD: arith = 1'b1;
            CMD_SUB: arith = 1'b1;
            CMD_CMP: arith = 1'b1;
            CMD_CMN: arith = 1'b1;
            CMD_ADC: arith = 1'b1;
            default: arith = 1'b0;
        endcase
        return arith;
    endfunction

    // Compare/test commands only update flags, never the register file.
    function automatic logic cmd_is_flag_only(input logic [3:0] cmd);
        logic fo;
        case (cmd)
            CMD_CMP: fo = 1'b1;
            CMD_TST: fo = 1'b1;
            CMD_CMN: fo = 1'b1;
            default: fo = 1'b0;
        endcase
        return fo;
    endfunction

    state_t               state_r;
    state_t               state_next_s;

    logic [3:0]           cmd_s;
    logic                 s_bit_s;
    logic                 rd_is_pc_s;

    logic                 pc_write_s;
    logic                 adr_src_s;
    logic                 ir_write_s;
    logic                 mem_w_s;
    logic                 reg_w_s;
    logic                 alu_src_a_s;
    logic [1:0]           alu_src_b_s;
    logic [1:0]           result_src_s;
    logic [1:0]           imm_src_s;
    logic [1:0]           reg_src_s;
    logic [ALU_CTL_W-1:0] alu_control_s;
    logic [1:0]           flag_w_s;
    logic                 shift_flag_s;
    logic                 trap_s;

    assign cmd_s      = bus.funct[4:1];
    assign s_bit_s    = bus.funct[0];
    assign rd_is_pc_s = (bus.rd == 4'd15);

    // State register: asynchronous reset returns to FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = S_FETCH;
        case (state_r)
            S_FETCH:  state_next_s = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    2'd0:    state_next_s = bus.funct[5] ? S_EXECI : S_EXECR;
                    2'd1:    state_next_s = S_MEMADR;
                    2'd2:    state_next_s = S_BRANCH;
`ifdef MC_ILLEGAL_TRAP_EN
                    2'd3:    state_next_s = S_TRAP;
`else
                    2'd3:    state_next_s = S_FETCH;
`endif
                    default: state_next_s = S_FETCH;
                endcase
            end
            S_MEMADR: state_next_s = s_bit_s ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_next_s = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_next_s = S_FETCH;
            S_MEMWR:  state_next_s = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_EXECR:  state_next_s = S_ALUWB;
            S_EXECI:  state_next_s = S_ALUWB;
            S_ALUWB:  state_next_s = S_FETCH;
            S_BRANCH: state_next_s = S_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
            S_TRAP:   state_next_s = S_TRAP;
`endif
            default:  state_next_s = S_FETCH;
        endcase
    end

    // Per-state datapath controls; cond_ex gates every architectural write.
    always_comb begin
        pc_write_s    = 1'b0;
        adr_src_s     = 1'b0;
        ir_write_s    = 1'b0;
        mem_w_s       = 1'b0;
        reg_w_s       = 1'b0;
        alu_src_a_s   = 1'b0;
        alu_src_b_s   = 2'd0;
        result_src_s  = 2'd0;
        imm_src_s     = 2'd0;
        reg_src_s     = 2'd0;
        alu_control_s = ALU_CTL_W'(ALU_ADD);
        flag_w_s      = 2'd0;
        shift_flag_s  = 1'b0;
        trap_s        = 1'b0;
        case (state_r)
            S_FETCH: begin
                // PC+4 is computed and written back as soon as the fetch completes
                alu_src_a_s  = 1'b1;
                alu_src_b_s  = 2'd2;
                result_src_s = 2'd2;
                ir_write_s   = bus.mem_ready;
                pc_write_s   = bus.mem_ready;
            end
            S_DECODE: begin
                // PC+8 precomputed into ALUOut for branch-relative use
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'd2;
            end
            S_MEMADR: begin
                alu_src_b_s = 2'd1;
                imm_src_s   = 2'd1;
            end
            S_MEMRD: begin
                adr_src_s = 1'b1;
            end
            S_MEMWB: begin
                result_src_s = 2'd1;
                reg_w_s      = bus.cond_ex;
            end
            S_MEMWR: begin
                adr_src_s = 1'b1;
                reg_src_s = 2'b10;
                mem_w_s   = bus.cond_ex;
            end
            S_EXECR, S_EXECI: begin
                alu_src_b_s   = (state_r == S_EXECI) ? 2'd1 : 2'd0;
                alu_control_s = ALU_CTL_W'(cmd_to_alu(cmd_s));
                flag_w_s[1]   = s_bit_s & bus.cond_ex;
                flag_w_s[0]   = s_bit_s & bus.cond_ex & cmd_is_arith(cmd_s);
                shift_flag_s  = (cmd_s == CMD_LSL);
            end
            S_ALUWB: begin
                result_src_s = 2'd0;
                reg_w_s      = bus.cond_ex & ~cmd_is_flag_only(cmd_s);
            end
            S_BRANCH: begin
                reg_src_s    = 2'b01;
                imm_src_s    = 2'd2;
                alu_src_b_s  = 2'd1;
                result_src_s = 2'd2;
                pc_write_s   = bus.cond_ex;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            S_TRAP: begin
                trap_s = 1'b1;
            end
`endif
            default: begin
                trap_s = 1'b0;
            end
        endcase
        // A register write to r15 redirects the result into the PC.
        pc_write_s = pc_write_s | (reg_w_s & rd_is_pc_s);
    end

    // While reset is held every enable, strobe and select is forced low,
    // including the FETCH defaults the state register already points at.
    assign bus.pc_write    = pc_write_s   & rst_n;
    assign bus.adr_src     = adr_src_s    & rst_n;
    assign bus.ir_write    = ir_write_s   & rst_n;
    assign bus.mem_w       = mem_w_s      & rst_n;
    assign bus.reg_w       = reg_w_s      & rst_n;
    assign bus.alu_src_a   = alu_src_a_s  & rst_n;
    assign bus.alu_src_b   = alu_src_b_s  & {2{rst_n}};
    assign bus.result_src  = result_src_s & {2{rst_n}};
    assign bus.imm_src     = imm_src_s    & {2{rst_n}};
    assign bus.reg_src     = reg_src_s    & {2{rst_n}};
    assign bus.alu_control = alu_control_s & {ALU_CTL_W{rst_n}};
    assign bus.flag_w      = flag_w_s     & {2{rst_n}};
    assign bus.shift_flag  = shift_flag_s & rst_n;
    assign bus.trap        = trap_s       & rst_n;

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
// Directed stimulus drives one instruction cycle at a time and pushes the
// hand-derived control vector for that cycle into a queue; a monitor pops and
// compares on every falling edge.
// Vector layout (21 bits): pc_write adr_src ir_write mem_w reg_w alu_src_a
//   alu_src_b[1:0] result_src[1:0] imm_src[1:0] reg_src[1:0] alu_control[2:0]
//   flag_w[1:0] shift_flag trap
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

    logic clk;
    logic rst_n;

    multicycle_controller_if #(.ALU_CTL_W(3)) bus ();

    multicycle_controller #(.ALU_CTL_W(3), .STATE_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [20:0] v;
        int          id;
    } exp_t;

    exp_t q[$];
    exp_t e_mon;
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;

    localparam logic [20:0] ZERO = 21'd0;

    function automatic logic [20:0] pk(input logic pcw, input logic adr, input logic irw,
                                       input logic mw, input logic rw, input logic a,
                                       input logic [1:0] b, input logic [1:0] res,
                                       input logic [1:0] imm, input logic [1:0] rs,
                                       input logic [2:0] alu, input logic [1:0] fl,
                                       input logic sh, input logic tr);
        return {pcw, adr, irw, mw, rw, a, b, res, imm, rs, alu, fl, sh, tr};
    endfunction

    function automatic logic [20:0] f_fetch(input logic rdy);
        return pk(rdy, 1'b0, rdy, 1'b0, 1'b0, 1'b1, 2'd2, 2'd2, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0, 1'b0);
    endfunction
    function automatic logic [20:0] f_decode();
        return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0, 1'b0);
    endfunction
    function automatic logic [20:0] f_memadr();
        return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd1, 2'd0, 3'd0, 2'd0, 1'b0, 1'b0);
    endfunction
    function automatic logic [20:0] f_memrd();
        return pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0, 1'b0);
    endfunction
    function automatic logic [20:0] f_memwb(input logic rw, input logic pcw);
        return pk(pcw, 1'b0, 1'b0, 1'b0, rw, 1'b0, 2'd0, 2'd1, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0, 1'b0);
    endfunction
    function automatic logic [20:0] f_memwr(input logic mw);
        return pk(1'b0, 1'b1, 1'b0, mw, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd2, 3'd0, 2'd0, 1'b0, 1'b0);
    endfunction
    function automatic logic [20:0] f_exec(input logic imm, input logic [2:0] alu,
                                           input logic [1:0] fl, input logic sh);
        return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {1'b0, imm}, 2'd0, 2'd0, 2'd0, alu, fl, sh, 1'b0);
    endfunction
    function automatic logic [20:0] f_aluwb(input logic rw, input logic pcw);
        return pk(pcw, 1'b0, 1'b0, 1'b0, rw, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0, 1'b0);
    endfunction
    function automatic logic [20:0] f_branch(input logic pcw);
        return pk(pcw, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 2'd2, 2'd1, 3'd0, 2'd0, 1'b0, 1'b0);
    endfunction
    function automatic logic [20:0] f_trap();
        return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0, 1'b1);
    endfunction

    function automatic logic [20:0] actual();
        return {bus.pc_write, bus.adr_src, bus.ir_write, bus.mem_w, bus.reg_w, bus.alu_src_a,
                bus.alu_src_b, bus.result_src, bus.imm_src, bus.reg_src, bus.alu_control,
                bus.flag_w, bus.shift_flag, bus.trap};
    endfunction

    // One clock cycle: drive inputs just after the rising edge, queue expectation.
    task automatic step(input logic rst, input logic [1:0] o, input logic [5:0] f,
                        input logic [3:0] r, input logic c, input logic rdy,
                        input logic [20:0] e);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n         = rst;
        bus.op        = o;
        bus.funct     = f;
        bus.rd        = r;
        bus.cond_ex   = c;
        bus.mem_ready = rdy;
        x.v  = e;
        x.id = step_id;
        step_id++;
        q.push_back(x);
    endtask

    // Scoreboard monitor: compare DUT controls against the queued expectation.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            e_mon = q.pop_front();
            checks++;
            if (actual() !== e_mon.v) begin
                errors++;
                $display("FAIL ctl step %0d got %b exp %b", e_mon.id, actual(), e_mon.v);
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        bus.op        = 2'd0;
        bus.funct     = 6'd0;
        bus.rd        = 4'd0;
        bus.cond_ex   = 1'b1;
        bus.mem_ready = 1'b1;

        // reset held with mem_ready high: FETCH controls must stay masked
        step(1'b0, 2'd0, 6'b000000, 4'd0, 1'b1, 1'b1, ZERO);
        step(1'b0, 2'd0, 6'b000000, 4'd0, 1'b1, 1'b1, ZERO);

        // ADD r1,r2,r3
        step(1'b1, 2'd0, 6'b001000, 4'd1, 1'b1, 1'b1, f_fetch(1'b1));
        step(1'b1, 2'd0, 6'b001000, 4'd1, 1'b1, 1'b1, f_decode());
        step(1'b1, 2'd0, 6'b001000, 4'd1, 1'b1, 1'b1, f_exec(1'b0, 3'b000, 2'b00, 1'b0));
        step(1'b1, 2'd0, 6'b001000, 4'd1, 1'b1, 1'b1, f_aluwb(1'b1, 1'b0));

        // LDR with two memory wait cycles: 7 cycles total
        step(1'b1, 2'd1, 6'b011001, 4'd4, 1'b1, 1'b1, f_fetch(1'b1));
        step(1'b1, 2'd1, 6'b011001, 4'd4, 1'b1, 1'b1, f_decode());
        step(1'b1, 2'd1, 6'b011001, 4'd4, 1'b1, 1'b1, f_memadr());
        step(1'b1, 2'd1, 6'b011001, 4'd4, 1'b1, 1'b0, f_memrd());
        step(1'b1, 2'd1, 6'b011001, 4'd4, 1'b1, 1'b0, f_memrd());
        step(1'b1, 2'd1, 6'b011001, 4'd4, 1'b1, 1'b1, f_memrd());
        step(1'b1, 2'd1, 6'b011001, 4'd4, 1'b1, 1'b1, f_memwb(1'b1, 1'b0));

        // CMP: sub, both flag groups, no register write
        step(1'b1, 2'd0, 6'b010101, 4'd0, 1'b1, 1'b1, f_fetch(1'b1));
        step(1'b1, 2'd0, 6'b010101, 4'd0, 1'b1, 1'b1, f_decode());
        step(1'b1, 2'd0, 6'b010101, 4'd0, 1'b1, 1'b1, f_exec(1'b0, 3'b001, 2'b11, 1'b0));
        step(1'b1, 2'd0, 6'b010101, 4'd0, 1'b1, 1'b1, f_aluwb(1'b0, 1'b0));

        // B not taken
        step(1'b1, 2'd2, 6'b000000, 4'd0, 1'b0, 1'b1, f_fetch(1'b1));
        step(1'b1, 2'd2, 6'b000000, 4'd0, 1'b0, 1'b1, f_decode());
        step(1'b1, 2'd2, 6'b000000, 4'd0, 1'b0, 1'b1, f_branch(1'b0));

        // B taken
        step(1'b1, 2'd2, 6'b000000, 4'd0, 1'b1, 1'b1, f_fetch(1'b1));
        step(1'b1, 2'd2, 6'b000000, 4'd0, 1'b1, 1'b1, f_decode());
        step(1'b1, 2'd2, 6'b000000, 4'd0, 1'b1, 1'b1, f_branch(1'b1));

        // ADD rd=15: result goes to PC
        step(1'b1, 2'd0, 6'b001000, 4'd15, 1'b1, 1'b1, f_fetch(1'b1));
        step(1'b1, 2'd0, 6'b001000, 4'd15, 1'b1, 1'b1, f_decode());
        step(1'b1, 2'd0, 6'b001000, 4'd15, 1'b1, 1'b1, f_exec(1'b0, 3'b000, 2'b00, 1'b0));
        step(1'b1, 2'd0, 6'b001000, 4'd15, 1'b1, 1'b1, f_aluwb(1'b1, 1'b1));

        // ADDS rd=15 with cond_ex=0: every write suppressed
        step(1'b1, 2'd0, 6'b001001, 4'd15, 1'b0, 1'b1, f_fetch(1'b1));
        step(1'b1, 2'd0, 6'b001001, 4'd15, 1'b0, 1'b1, f_decode());
        step(1'b1, 2'd0, 6'b001001, 4'd15, 1'b0, 1'b1, f_exec(1'b0, 3'b000, 2'b00, 1'b0));
        step(1'b1, 2'd0, 6'b001001, 4'd15, 1'b0, 1'b1, f_aluwb(1'b0, 1'b0));

        // ANDS immediate: EXECI, logical so only NZ flags
        step(1'b1, 2'd0, 6'b100001, 4'd2, 1'b1, 1'b1, f_fetch(1'b1));
        step(1'b1, 2'd0, 6'b100001, 4'd2, 1'b1, 1'b1, f_decode());
        step(1'b1, 2'd0, 6'b100001, 4'd2, 1'b1, 1'b1, f_exec(1'b1, 3'b010, 2'b10, 1'b0));
        step(1'b1, 2'd0, 6'b100001, 4'd2, 1'b1, 1'b1, f_aluwb(1'b1, 1'b0));

        // LSL: add plus shift_flag
        step(1'b1, 2'd0, 6'b011010, 4'd3, 1'b1, 1'b1, f_fetch(1'b1));
        step(1'b1, 2'd0, 6'b011010, 4'd3, 1'b1, 1'b1, f_decode());
        step(1'b1, 2'd0, 6'b011010, 4'd3, 1'b1, 1'b1, f_exec(1'b0, 3'b000, 2'b00, 1'b1));
        step(1'b1, 2'd0, 6'b011010, 4'd3, 1'b1, 1'b1, f_aluwb(1'b1, 1'b0));

        // EORS, ADCS, ORR, TST decode in EXECR
        step(1'b1, 2'd0, 6'b000011, 4'd3, 1'b1, 1'b1, f_fetch(1'b1));
        step(1'b1, 2'd0, 6'b000011, 4'd3, 1'b1, 1'b1, f_decode());
        step(1'b1, 2'd0, 6'b000011, 4'd3, 1'b1, 1'b1, f_exec(1'b0, 3'b111, 2'b10, 1'b0));
        step(1'b1, 2'd0, 6'b000011, 4'd3, 1'b1, 1'b1, f_aluwb(1'b1, 1'b0));
        step(1'b1, 2'd0, 6'b001011, 4'd3, 1'b1, 1'b1, f_fetch(1'b1));
        step(1'b1, 2'd0, 6'b001011, 4'd3, 1'b1, 1'b1, f_decode());
        step(1'b1, 2'd0, 6'b001011, 4'd3, 1'b1, 1'b1, f_exec(1'b0, 3'b100, 2'b11, 1'b0));
        step(1'b1, 2'd0, 6'b001011, 4'd3, 1'b1, 1'b1, f_aluwb(1'b1, 1'b0));
        step(1'b1, 2'd0, 6'b011000, 4'd3, 1'b1, 1'b1, f_fetch(1'b1));
        step(1'b1, 2'd0, 6'b011000, 4'd3, 1'b1, 1'b1, f_decode());
        step(1'b1, 2'd0, 6'b011000, 4'd3, 1'b1, 1'b1, f_exec(1'b0, 3'b011, 2'b00, 1'b0));
        step(1'b1, 2'd0, 6'b011000, 4'd3, 1'b1, 1'b1, f_aluwb(1'b1, 1'b0));
        step(1'b1, 2'd0, 6'b010001, 4'd3, 1'b1, 1'b1, f_fetch(1'b1));
        step(1'b1, 2'd0, 6'b010001, 4'd3, 1'b1, 1'b1, f_decode());
        step(1'b1, 2'd0, 6'b010001, 4'd3, 1'b1, 1'b1, f_exec(1'b0, 3'b010, 2'b10, 1'b0));
        step(1'b1, 2'd0, 6'b010001, 4'd3, 1'b1, 1'b1, f_aluwb(1'b0, 1'b0));

        // STR with one fetch wait and one write wait
        step(1'b1, 2'd1, 6'b011000, 4'd5, 1'b1, 1'b0, f_fetch(1'b0));
        step(1'b1, 2'd1, 6'b011000, 4'd5, 1'b1, 1'b1, f_fetch(1'b1));
        step(1'b1, 2'd1, 6'b011000, 4'd5, 1'b1, 1'b1, f_decode());
        step(1'b1, 2'd1, 6'b011000, 4'd5, 1'b1, 1'b1, f_memadr());
        step(1'b1, 2'd1, 6'b011000, 4'd5, 1'b1, 1'b0, f_memwr(1'b1));
        step(1'b1, 2'd1, 6'b011000, 4'd5, 1'b1, 1'b1, f_memwr(1'b1));

        // STR with cond_ex=0: strobe suppressed
        step(1'b1, 2'd1, 6'b011000, 4'd5, 1'b0, 1'b1, f_fetch(1'b1));
        step(1'b1, 2'd1, 6'b011000, 4'd5, 1'b0, 1'b1, f_decode());
        step(1'b1, 2'd1, 6'b011000, 4'd5, 1'b0, 1'b1, f_memadr());
        step(1'b1, 2'd1, 6'b011000, 4'd5, 1'b0, 1'b1, f_memwr(1'b0));

        // STR interrupted by reset while stalled in MEMWR
        step(1'b1, 2'd1, 6'b011000, 4'd5, 1'b1, 1'b1, f_fetch(1'b1));
        step(1'b1, 2'd1, 6'b011000, 4'd5, 1'b1, 1'b1, f_decode());
        step(1'b1, 2'd1, 6'b011000, 4'd5, 1'b1, 1'b1, f_memadr());
        step(1'b1, 2'd1, 6'b011000, 4'd5, 1'b1, 1'b0, f_memwr(1'b1));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.mem_w !== 1'b0) begin
            errors++;
            $display("FAIL mem_w_at_reset got %b exp 0", bus.mem_w);
        end
        step(1'b0, 2'd3, 6'b000000, 4'd0, 1'b1, 1'b1, ZERO);

        // release: FETCH with PC addressing, then an illegal opcode
        step(1'b1, 2'd3, 6'b000000, 4'd0, 1'b1, 1'b0, f_fetch(1'b0));
        step(1'b1, 2'd3, 6'b000000, 4'd0, 1'b1, 1'b1, f_fetch(1'b1));
        step(1'b1, 2'd3, 6'b000000, 4'd0, 1'b1, 1'b1, f_decode());
`ifdef MC_ILLEGAL_TRAP_EN
        step(1'b1, 2'd3, 6'b000000, 4'd0, 1'b1, 1'b1, f_trap());
        step(1'b1, 2'd0, 6'b001000, 4'd1, 1'b1, 1'b1, f_trap());
        step(1'b0, 2'd0, 6'b001000, 4'd1, 1'b1, 1'b1, ZERO);
        step(1'b1, 2'd0, 6'b001000, 4'd1, 1'b1, 1'b1, f_fetch(1'b1));
`else
        step(1'b1, 2'd0, 6'b001000, 4'd1, 1'b1, 1'b1, f_fetch(1'b1));
        step(1'b1, 2'd0, 6'b001000, 4'd1, 1'b1, 1'b1, f_decode());
`endif

        // drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 20 && q.size() != 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got %0d pending exp 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
